// File: rtl/gnrl_lden_arb_if.sv
// rtl/gnrl_lden_arb_if.sv - requester/bank bundle between N writers and the shared load-enabled register
interface gnrl_lden_arb_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_dat;
  logic [N-1:0]    gnt;
  logic            lden;
  logic [DW-1:0]   dnxt;
  logic            busy;
  logic            tmo_err;

  modport master (
    output req, req_last, req_dat,
    input  gnt, lden, dnxt, busy, tmo_err
  );

  modport slave (
    input  req, req_last, req_dat,
    output gnt, lden, dnxt, busy, tmo_err
  );
endinterface

// File: rtl/gnrl_lden_arb.sv
// rtl/gnrl_lden_arb.sv - round-robin arbiter with multi-beat locking in front of a shared lden/dnxt register
// Optional idle-owner timeout enabled by defining GNRL_LDEN_ARB_TIMEOUT_EN.
module gnrl_lden_arb #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int TMO_CYC = 16
) (
  input logic           clk,
  input logic           rst,
  gnrl_lden_arb_if.slave bus
);

  localparam int PW = $clog2(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("gnrl_lden_arb: N out of range 2..16");
  end
  if (TMO_CYC < 2 || TMO_CYC > 255) begin : g_bad_tmo
    $error("gnrl_lden_arb: TMO_CYC out of range 2..255");
  end

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;

  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] sel;
  logic          sel_v;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] idx);
    return (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Rotating priority search starting at ptr; explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    sel   = (state == S_IDLE) ? win : own;
    sel_v = (state == S_IDLE) ? found : bus.req[own];
    if (rst) sel_v = 1'b0;
  end

  assign bus.gnt  = sel_v ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  assign bus.lden = |(bus.req & bus.gnt);
  assign bus.dnxt = bus.lden ? bus.req_dat[int'(sel)*DW +: DW] : '0;
  assign bus.busy = !rst && (state == S_LOCK);

`ifdef GNRL_LDEN_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       tmo_q;

  assign bus.tmo_err = !rst && tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (state == S_IDLE) begin
        if (found) begin
          if (bus.req_last[win]) begin
            ptr <= ptr_nxt(win);
          end else begin
            state <= S_LOCK;
            own   <= win;
            cnt   <= '0;
          end
        end
      end else if (bus.req[own]) begin
        cnt <= '0;
        if (bus.req_last[own]) begin
          state <= S_IDLE;
          ptr   <= ptr_nxt(own);
        end
      end else if (cnt == 8'(TMO_CYC - 1)) begin
        // Owner went silent too long: release the lock and demote it like a normal finish.
        state <= S_IDLE;
        ptr   <= ptr_nxt(own);
        cnt   <= '0;
        tmo_q <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
`else
  assign bus.tmo_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      own   <= '0;
    end else if (state == S_IDLE) begin
      if (found) begin
        if (bus.req_last[win]) begin
          ptr <= ptr_nxt(win);
        end else begin
          state <= S_LOCK;
          own   <= win;
        end
      end
    end else if (bus.req[own] && bus.req_last[own]) begin
      state <= S_IDLE;
      ptr   <= ptr_nxt(own);
    end
  end
`endif

endmodule

// File: tb/tb_gnrl_lden_arb.sv
// tb/tb_gnrl_lden_arb.sv - directed self-checking bench for gnrl_lden_arb (N=4 and N=3 instances, TMO_CYC=4)
module tb_gnrl_lden_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gnrl_lden_arb_if #(.N(4), .DW(32)) b4();
  gnrl_lden_arb_if #(.N(3), .DW(32)) b3();

  gnrl_lden_arb #(.N(4), .DW(32), .TMO_CYC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  gnrl_lden_arb #(.N(3), .DW(32), .TMO_CYC(4)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat4(input int i);
    return 32'(32'h1111_1111 * (i + 1));
  endfunction

  function automatic logic [31:0] dat3(input int i);
    return 32'(32'hA000_0000 + i);
  endfunction

  task automatic drive4(input logic [3:0] r, input logic [3:0] l);
    b4.req      = r;
    b4.req_last = l;
  endtask

  task automatic exp4(input string tag, input logic [3:0] g, input logic [31:0] d,
                      input logic b, input logic t);
    @(negedge clk);
    check({tag, ".gnt"},  64'(b4.gnt),     64'(g));
    check({tag, ".lden"}, 64'(b4.lden),    64'(g != 4'b0000));
    check({tag, ".dnxt"}, 64'(b4.dnxt),    64'(d));
    check({tag, ".busy"}, 64'(b4.busy),    64'(b));
    check({tag, ".tmo"},  64'(b4.tmo_err), 64'(t));
    @(posedge clk);
    #1;
  endtask

  task automatic exp3(input string tag, input logic [2:0] g, input logic [31:0] d);
    @(negedge clk);
    check({tag, ".gnt"},  64'(b3.gnt),  64'(g));
    check({tag, ".lden"}, 64'(b3.lden), 64'(g != 3'b000));
    check({tag, ".dnxt"}, 64'(b3.dnxt), 64'(d));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) b4.req_dat[i*32 +: 32] = dat4(i);
    for (int i = 0; i < 3; i++) b3.req_dat[i*32 +: 32] = dat3(i);
    b3.req      = 3'b000;
    b3.req_last = 3'b000;
    drive4(4'b1111, 4'b1111);
    #1;

    // reset holds everything quiet even with all requesters active
    exp4("rst0", 4'b0000, 32'h0, 1'b0, 1'b0);
    exp4("rst1", 4'b0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // single-beat round robin, first grant right after release
    exp4("rr0", 4'b0001, dat4(0), 1'b0, 1'b0);
    exp4("rr1", 4'b0010, dat4(1), 1'b0, 1'b0);
    exp4("rr2", 4'b0100, dat4(2), 1'b0, 1'b0);
    exp4("rr3", 4'b1000, dat4(3), 1'b0, 1'b0);
    exp4("rr4", 4'b0001, dat4(0), 1'b0, 1'b0);

    rst = 1'b1;
    drive4(4'b0000, 4'b0000);
    exp4("rstp", 4'b0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // multi-beat lock by 0 while 2 waits
    drive4(4'b0101, 4'b0000);
    exp4("lk0", 4'b0001, dat4(0), 1'b0, 1'b0);
    exp4("lk1", 4'b0001, dat4(0), 1'b1, 1'b0);
    exp4("lk2", 4'b0001, dat4(0), 1'b1, 1'b0);
    drive4(4'b0101, 4'b0001);
    exp4("lk3", 4'b0001, dat4(0), 1'b1, 1'b0);
    drive4(4'b0101, 4'b0100);
    exp4("lk4", 4'b0100, dat4(2), 1'b0, 1'b0);

    // owner 2 bubbles while 1 requests
    drive4(4'b0100, 4'b0000);
    exp4("bb0", 4'b0100, dat4(2), 1'b0, 1'b0);
    drive4(4'b0010, 4'b0000);
    exp4("bb1", 4'b0000, 32'h0, 1'b1, 1'b0);
    exp4("bb2", 4'b0000, 32'h0, 1'b1, 1'b0);
    drive4(4'b0110, 4'b0100);
    exp4("bb3", 4'b0100, dat4(2), 1'b1, 1'b0);
    drive4(4'b0010, 4'b0010);
    exp4("bb4", 4'b0010, dat4(1), 1'b0, 1'b0);

    // owner 1 goes silent for four cycles, 3 waits
    drive4(4'b0010, 4'b0000);
    exp4("to0", 4'b0010, dat4(1), 1'b0, 1'b0);
    drive4(4'b1000, 4'b1000);
    for (int k = 0; k < 4; k++) exp4($sformatf("to_b%0d", k), 4'b0000, 32'h0, 1'b1, 1'b0);
`ifdef GNRL_LDEN_ARB_TIMEOUT_EN
    exp4("to_hit", 4'b1000, dat4(3), 1'b0, 1'b1);
    exp4("to_aft", 4'b1000, dat4(3), 1'b0, 1'b0);
`else
    exp4("to_hit", 4'b0000, 32'h0, 1'b1, 1'b0);
    exp4("to_aft", 4'b0000, 32'h0, 1'b1, 1'b0);
`endif

    // reset in the middle of whatever state we are in
    rst = 1'b1;
    exp4("rstm", 4'b0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    exp4("rstm_rel", 4'b1000, dat4(3), 1'b0, 1'b0);

    // a beat from the owner restarts the idle count
    drive4(4'b0001, 4'b0000);
    exp4("cc0", 4'b0001, dat4(0), 1'b0, 1'b0);
    drive4(4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) exp4($sformatf("cc_a%0d", k), 4'b0000, 32'h0, 1'b1, 1'b0);
    drive4(4'b0001, 4'b0000);
    exp4("cc_beat", 4'b0001, dat4(0), 1'b1, 1'b0);
    drive4(4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) exp4($sformatf("cc_b%0d", k), 4'b0000, 32'h0, 1'b1, 1'b0);
    drive4(4'b0001, 4'b0001);
    exp4("cc_end", 4'b0001, dat4(0), 1'b1, 1'b0);
    drive4(4'b0000, 4'b0000);
    exp4("cc_idle", 4'b0000, 32'h0, 1'b0, 1'b0);

    // N=3: move ptr to 2, then search must wrap 2 -> 0
    b3.req      = 3'b010;
    b3.req_last = 3'b111;
    exp3("n3_0", 3'b010, dat3(1));
    b3.req = 3'b011;
    exp3("n3_wrap", 3'b001, dat3(0));
    exp3("n3_next", 3'b010, dat3(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gnrl_lden_arb.md
Name: gnrl_lden_arb

Overview:
- Round-robin arbiter that shares one load-enabled register bank (clk/lden/dnxt/qout DFF primitive) among N requesters.
- Selects one requester and drives the bank's lden and dnxt. Returns a one-hot grant that acts as the requester's ready.
- Supports multi-beat locked ownership: the grant sticks to one requester until it signals its last beat.
- Sits between general-purpose register/CSR writers and the shared DFF bank.

Parameters:
- N, 4, number of requesters; legal range 2..16, need not be a power of two.
- DW, 32, data width of the shared register.
- TMO_CYC, 16, idle-owner timeout in cycles; legal range 2..255; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  per-requester valid.
- req_last  input  N  per-requester last-beat flag; sampled only while that requester's req=1.
- req_dat  input  N*DW  per-requester data; slice i = bits [i*DW +: DW].
- gnt  output  N  one-hot grant, combinational; beat i is transferred when req[i]&gnt[i].
- lden  output  1  load enable to the shared DFF bank; equals |(req&gnt).
- dnxt  output  DW  data to the shared DFF bank; req_dat slice of the granted requester, 0 when lden=0.
- busy  output  1  1 while a multi-beat lock is held.
- tmo_err  output  1  one-cycle pulse when a lock is broken by timeout.

Behaviour:
- Internal state: FSM {IDLE, LOCK}; round-robin pointer ptr; owner index own.
  - ptr and own are each ceil(log2 N) bits wide.
  - Reset values: FSM=IDLE, ptr=0, own=0, timeout counter=0.
- While rst=1: gnt=0, lden=0, dnxt=0, busy=0, tmo_err=0, no transfer. Reset mid-lock drops ownership immediately, with no cleanup beat.
- Pointer update: ptr_nxt = (idx==N-1) ? 0 : idx+1. Explicit wrap, no modulo on non-power-of-two N.
- IDLE:
  - winner w = first index with req=1, searching ptr, ptr+1, ..., wrapping at N-1 to 0.
  - If any req: gnt=onehot(w), lden=1, dnxt=req_dat[w] in the same cycle. Zero-cycle latency from req to grant.
  - If req_last[w]=1: stay IDLE, ptr <= ptr_nxt(w).
  - If req_last[w]=0: go to LOCK, own <= w; ptr unchanged.
  - No req: gnt=0, lden=0, state unchanged.
- LOCK:
  - gnt = req[own] ? onehot(own) : 0. All other requesters see gnt=0 regardless of their req.
  - busy=1.
  - req[own]=1 and req_last[own]=1: beat transferred; go to IDLE, ptr <= ptr_nxt(own). Next cycle is a fresh IDLE arbitration.
  - req[own]=1 and req_last[own]=0: beat transferred; stay LOCK.
  - req[own]=0: bubble; lden=0; stay LOCK.
- Fairness: after any completed transaction, the finishing index becomes lowest priority.
- Simultaneous events:
  - A single-beat winner in IDLE with other reqs pending: next cycle's arbitration uses the updated ptr.
  - A last beat and new requests in the same cycle: new requests are not granted until the following cycle.
- gnt has at most one bit set in every cycle. lden=1 implies exactly one gnt bit is set.

Optional Feature:
- Macro: GNRL_LDEN_ARB_TIMEOUT_EN.
- Enabled: an 8-bit counter runs only in LOCK.
  - Clears on entering LOCK and on every beat from own.
  - Increments on each bubble cycle (req[own]=0).
  - When the counter reaches TMO_CYC-1 on a bubble cycle: FSM <= IDLE, ptr <= ptr_nxt(own), counter <= 0. tmo_err=1 during the following cycle only.
- Disabled: no counter logic is synthesized, tmo_err is tied to 0, and a lock is held indefinitely.

Test Plan (N=4, DW=32, TMO_CYC=4):
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, lden=0, dnxt=0, busy=0. After the rst release edge, req=1111, req_last=1111 -> gnt=0001, dnxt=req_dat[0].
- Round-robin: req=1111, req_last=1111 held 5 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001; lden=1 every cycle.
- Lock: cycle 0 req=0101, req_last=0000 -> gnt=0001, busy=1 next cycle.
  - Cycles 1-2 req=0101 -> gnt=0001.
  - Cycle 3 req_last[0]=1 -> gnt=0001, then IDLE.
  - Cycle 4 -> gnt=0100.
- Bubble in lock: owner 2 locked, req[2]=0 for 2 cycles with req[1]=1 -> gnt=0000, lden=0, dnxt=0. Then req[2]=1, req_last[2]=1 -> gnt=0100, dnxt=req_dat[2].
- Wrap and non-power-of-two: N=3, ptr=2, req=011 -> gnt=001, then gnt=010.
- Timeout (macro on): owner 1 locked, req[1]=0 for 4 cycles, req[3]=1 -> tmo_err=1 for one cycle after the 4th bubble. In that same cycle (FSM back to IDLE) gnt=1000. Macro off: same stimulus -> gnt stays 0000 and busy=1 indefinitely.
